// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing helpers for the sequential divider
package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width; a 1-bit counter is the floor so WIDTH=1 still elaborates.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: trial subtract, sign test, select
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o,
  output logic             q_o
);

  logic [WIDTH:0] trial;

  // A non-negative trial difference means the divisor fits: keep the difference, quotient bit 1.
  always_comb begin
    trial = {p_i, msb_i} - {1'b0, b_i};
    q_o   = ~trial[WIDTH];
    p_o   = q_o ? trial[WIDTH-1:0] : {p_i[WIDTH-2:0], msb_i};
  end

endmodule

// File: rtl/div4bits_seq.sv
// rtl/div4bits_seq.sv - sequential restoring divider with start/done handshake (option: DIV4_EARLY_EXIT_EN)
module div4bits_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             DivZero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient bits fill the LSBs
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_p;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i   (p_q),
    .msb_i (dvd_q[WIDTH-1]),
    .b_i   (dvs_q),
    .p_o   (step_p),
    .q_o   (step_q)
  );

  // State and datapath registers; reset abandons any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and datapath update; results only change on the transition into DONE.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (B == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = A;
            dz_d    = 1'b1;
          end
`ifdef DIV4_EARLY_EXIT_EN
          else if (A < B) begin
            state_d = DONE;
            q_d     = '0;
            r_d     = A;
            dz_d    = 1'b0;
          end
`endif
          else begin
            state_d = CALC;
            dvd_d   = A;
            dvs_d   = B;
            p_d     = '0;
            cnt_d   = CW'(WIDTH - 1);
          end
        end
      end

      CALC: begin
        p_d   = step_p;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = DONE;
          q_d     = {dvd_q[WIDTH-2:0], step_q};
          r_d     = step_p;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign Q       = q_q;
  assign R       = r_q;
  assign DivZero = dz_q;

endmodule

// File: tb/tb_div4bits_seq.sv
// tb/tb_div4bits_seq.sv - self-checking bench for div4bits_seq against an arithmetic reference
module tb_div4bits_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Q, R;
  logic         busy, done, DivZero;

  int vectors = 0;
  int miscompares = 0;

  div4bits_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .Q       (Q),
    .R       (R),
    .busy    (busy),
    .done    (done),
    .DivZero (DivZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples are taken on falling edges. lat counts samples from the one right after the
  // accepting edge (1) until done is seen: DONE entered directly -> 1, full run -> W+1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eq, er;
    logic         edz;
    int           elat, n;
    bit           busy_ok;
    edz  = (b == 0);
    eq   = edz ? 4'hF : W'(int'(a) / int'(b));
    er   = edz ? a : W'(int'(a) % int'(b));
    elat = W + 1;
    if (edz) elat = 1;
`ifdef DIV4_EARLY_EXIT_EN
    if (!edz && a < b) elat = 1;
`endif
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    n = 1; busy_ok = 1'b1;
    while (!done && n < 30) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, elat);
    chk({tag, ".busy_during"}, busy_ok & busy, 1);
    chk({tag, ".Q"}, Q, eq);
    chk({tag, ".R"}, R, er);
    chk({tag, ".DivZero"}, DivZero, edz);
    @(negedge clk);
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".Q_hold"}, Q, eq);
    chk({tag, ".R_hold"}, R, er);
    chk({tag, ".DZ_hold"}, DivZero, edz);
  endtask

  initial begin
    int nd;
    logic [W-1:0] q_seen, r_seen;

    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.Q", Q, 0);
    chk("rst.R", R, 0);
    chk("rst.DivZero", DivZero, 0);
    rst_n = 1'b1;

    run_op(4'd13, 4'd3, "d13_3");
    run_op(4'd15, 4'd1, "d15_1");
    run_op(4'd15, 4'd15, "d15_15");
    run_op(4'd0, 4'd5, "d0_5");
    run_op(4'd7, 4'd0, "d7_0");
    run_op(4'd9, 4'd2, "d9_2");
    run_op(4'd2, 4'd9, "d2_9");

    // Restart attempt two cycles into a division must be ignored.
    @(negedge clk);
    A = 4'd12; B = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd1; B = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; q_seen = '0; r_seen = '0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        nd++;
        q_seen = Q;
        r_seen = R;
      end
      @(negedge clk);
    end
    chk("restart.done_count", nd, 1);
    chk("restart.Q", q_seen, 2);
    chk("restart.R", r_seen, 2);

    // Reset in the middle of a division.
    @(negedge clk);
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.Q", Q, 0);
    chk("midrst.R", R, 0);
    chk("midrst.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("midrst.no_done", nd, 0);
    run_op(4'd13, 4'd3, "post_rst");

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 15));
      rb = (i % 8 == 0) ? 4'd0 : W'($urandom_range(0, 15));
      run_op(ra, rb, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div4bits_seq.md
Name: div4bits_seq

Overview:
- Sequential restoring divider; computes Q = A / B and R = A % B, one quotient bit per clock.
- Sits beside the combinational 4-bit add/subtract units in the lab ALU.
- Consumes the subtract-and-test-sign idea: each iteration's trial-subtract sign decides the quotient bit.
- Start/done handshake; results held until the next accepted start.

Parameters:
- WIDTH, 4, operand/result width in bits; also the iteration count.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  dividend, unsigned, latched when start is accepted
- B  input  WIDTH  divisor, unsigned, latched when start is accepted
- Q  output  WIDTH  quotient, registered
- R  output  WIDTH  remainder, registered
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; Q/R/DivZero valid from this cycle
- DivZero  output  1  B was 0 for the last accepted operation

Behaviour:
- Reset: rst_n low forces state IDLE at once (asynchronous). It also clears Q, R, done, DivZero, the internal partial remainder, the shift register and the counter. Reset mid-operation abandons the division; no done pulse follows.
- States are IDLE, CALC and DONE.
- IDLE, start=1 at edge k, B!=0:
  - Latch A into the dividend shift register and B into the divisor register.
  - Clear the partial remainder P and set cnt to WIDTH-1.
  - Go to CALC.
- IDLE, start=1 at edge k, B==0:
  - Go to DONE.
  - Set Q to all ones, R to A and DivZero to 1.
- CALC, each edge:
  - trial = {P, dividend MSB} - {0, B}, computed WIDTH+1 bits wide.
  - If trial is non-negative (MSB 0): P <= trial[WIDTH-1:0] and the quotient bit is 1.
  - Otherwise: P <= {P[WIDTH-2:0], dividend MSB} and the quotient bit is 0.
  - Shift the dividend left and shift the quotient bit into the LSB.
  - cnt decrements; the edge with cnt==0 moves to DONE, loads Q and R, and sets DivZero to 0.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start sampled at edge k gives done high in the cycle after edge k+WIDTH (WIDTH cycles); divide-by-zero gives done after edge k+1.
- start while in CALC or DONE is ignored and not queued. A and B changing during CALC has no effect.
- Q, R and DivZero hold their values through IDLE until the next accepted start updates them at its DONE entry.
- Arithmetic invariant: P < B, so R always fits in WIDTH bits and A == Q*B + R for B != 0.

Optional Feature:
- Macro DIV4_EARLY_EXIT_EN.
- Defined: at start acceptance with B!=0 and A<B, go directly to DONE with Q=0, R=A and DivZero=0 (latency 1 cycle).
- Undefined: every B!=0 operation takes the full WIDTH iterations.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package div_pkg holds:
  - the state encoding localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the counter width, computed as clog2(WIDTH).
- Sub-module div_step: purely combinational single iteration.
  - Inputs: P, dividend MSB and B.
  - Outputs: next P and the quotient bit.
  - Internally it is a WIDTH+1-bit subtract with a sign test.
- Top module holds the FSM, registers and handshake.

Test Plan:
- A=13, B=3, start pulse -> busy for 4 cycles; done pulse with Q=4, R=1, DivZero=0; Q/R held after done.
- A=15, B=1 -> Q=15, R=0. Then A=15, B=15 -> Q=1, R=0. Then A=0, B=5 -> Q=0, R=0.
- A=7, B=0 -> done 1 cycle after start; Q=4'hF, R=7, DivZero=1. The next op A=9, B=2 gives Q=4, R=1 and clears DivZero.
- A=2, B=9 -> Q=0, R=2. Latency is 4 cycles with DIV4_EARLY_EXIT_EN undefined and 1 cycle with it defined.
- start re-pulsed with A=1, B=1 two cycles into A=12, B=5 -> ignored; done once with Q=2, R=2.
- rst_n low for 1 cycle during CALC of A=13, B=3:
  - immediately busy=0, Q=0, R=0 and done=0, with no done pulse afterwards;
  - a new start after release works normally.
